// File: rtl/psram_bus_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : psram_bus_scheduler_if
// Description : Request, command-engine and bus-ownership signals of the
//               PSRAM bus scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface psram_bus_scheduler_if;
    logic        init_done;
    logic [9:0]  fifo_wrusedw;
    logic        fifo_wrfull;
    logic        mcu_req;
    logic        mcu_gnt;
    logic        wr_req;
    logic [21:0] wr_addr;
    logic        wr_ack;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [21:0] cmd_addr;
    logic        cmd_ready;
    logic        cmd_done;
    logic        psram_ctrl;
    logic        frame_start;

    // Scheduler side
    modport slave (
        input  init_done, fifo_wrusedw, fifo_wrfull, mcu_req, wr_req, wr_addr,
               cmd_ready, cmd_done,
        output mcu_gnt, wr_ack, cmd_valid, cmd_op, cmd_addr, psram_ctrl, frame_start
    );

    // Requesters and command engine side
    modport master (
        output init_done, fifo_wrusedw, fifo_wrfull, mcu_req, wr_req, wr_addr,
               cmd_ready, cmd_done,
        input  mcu_gnt, wr_ack, cmd_valid, cmd_op, cmd_addr, psram_ctrl, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/psram_bus_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : psram_bus_scheduler
// Description : Arbitrates the shared QSPI PSRAM between display refill, host
//               write bursts and the MCU pass-through window.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_bus_scheduler #(
    parameter logic [21:0] FB_BASE      = 22'h000000,
    parameter logic [21:0] FB_WORDS     = 22'd384000,
    parameter logic [7:0]  BURST_WORDS  = 8'd16,
    parameter logic [10:0] FIFO_DEPTH   = 11'd512,
    parameter logic [15:0] MCU_MAX_WAIT = 16'd1024
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    psram_bus_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_SELECT    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_BUSY      = 3'd3,
        ST_MCU_WIN   = 3'd4
    } state_t;

    localparam logic [1:0] c_op_read  = 2'd0;
    localparam logic [1:0] c_op_write = 2'd1;
    localparam logic [1:0] c_op_exit  = 2'd2;
    localparam logic [1:0] c_op_enter = 2'd3;

    state_t      state_q,       state_d;
    logic [1:0]  cmd_op_q,      cmd_op_d;
    logic [21:0] cmd_addr_q,    cmd_addr_d;
    logic        cmd_valid_q,   cmd_valid_d;
    logic        mcu_gnt_q,     mcu_gnt_d;
    logic        wr_ack_q,      wr_ack_d;
    logic        psram_ctrl_q,  psram_ctrl_d;
    logic        frame_start_q, frame_start_d;
    logic [21:0] disp_addr_q,   disp_addr_d;
    logic [15:0] starve_cnt_q,  starve_cnt_d;

    logic [10:0] w_fifo_room;
    logic        w_refill_ok;
    logic        w_mcu_urgent;
    logic [22:0] w_next_disp;
    logic [22:0] w_fb_end;

    // Room can wrap if the fill level exceeds the depth; that reads as "room".
    assign w_fifo_room  = FIFO_DEPTH - {1'b0, bus.fifo_wrusedw};
    assign w_refill_ok  = (w_fifo_room >= {3'b000, BURST_WORDS}) && !bus.fifo_wrfull;
    assign w_mcu_urgent = bus.mcu_req && (starve_cnt_q >= MCU_MAX_WAIT);
    assign w_next_disp  = {1'b0, disp_addr_q} + {15'd0, BURST_WORDS};
    assign w_fb_end     = {1'b0, FB_BASE} + {1'b0, FB_WORDS};

    always_comb begin
        state_d       = state_q;
        cmd_op_d      = cmd_op_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_valid_d   = cmd_valid_q;
        mcu_gnt_d     = mcu_gnt_q;
        wr_ack_d      = 1'b0;
        psram_ctrl_d  = psram_ctrl_q;
        frame_start_d = 1'b0;
        disp_addr_d   = disp_addr_q;

        case (state_q)
            ST_WAIT_INIT: begin
                if (bus.init_done) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_mcu_urgent) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = c_op_exit;
                    cmd_addr_d  = 22'd0;
                end else if (w_refill_ok) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = c_op_read;
                    cmd_addr_d  = disp_addr_q;
                end else if (bus.wr_req) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = c_op_write;
                    cmd_addr_d  = bus.wr_addr;
                end else if (bus.mcu_req) begin
                    state_d     = ST_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = c_op_exit;
                    cmd_addr_d  = 22'd0;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d       = ST_BUSY;
                    cmd_valid_d   = 1'b0;
                    frame_start_d = (cmd_op_q == c_op_read) && (disp_addr_q == FB_BASE);
                end
            end
            ST_BUSY: begin
                if (bus.cmd_done) begin
                    state_d = ST_SELECT;
                    case (cmd_op_q)
                        c_op_read: begin
                            disp_addr_d = (w_next_disp >= w_fb_end) ? FB_BASE : w_next_disp[21:0];
                        end
                        c_op_write: begin
                            wr_ack_d = 1'b1;
                        end
                        c_op_exit: begin
                            state_d      = ST_MCU_WIN;
                            psram_ctrl_d = 1'b0;
                            mcu_gnt_d    = bus.mcu_req;
                        end
                        default: begin
                            state_d = ST_SELECT;
                        end
                    endcase
                end
            end
            ST_MCU_WIN: begin
                // An ungranted window (request gone during exit) closes at once.
                if (!bus.mcu_req || !mcu_gnt_q) begin
                    state_d      = ST_ISSUE;
                    mcu_gnt_d    = 1'b0;
                    psram_ctrl_d = 1'b1;
                    cmd_valid_d  = 1'b1;
                    cmd_op_d     = c_op_enter;
                    cmd_addr_d   = 22'd0;
                end
            end
            default: begin
                state_d = ST_WAIT_INIT;
            end
        endcase

        if (!bus.mcu_req || (mcu_gnt_d && !mcu_gnt_q)) begin
            starve_cnt_d = 16'd0;
        end else if (!mcu_gnt_q && (starve_cnt_q != 16'hFFFF)) begin
            starve_cnt_d = starve_cnt_q + 16'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_WAIT_INIT;
            cmd_op_q      <= c_op_read;
            cmd_addr_q    <= 22'd0;
            cmd_valid_q   <= 1'b0;
            mcu_gnt_q     <= 1'b0;
            wr_ack_q      <= 1'b0;
            psram_ctrl_q  <= 1'b1;
            frame_start_q <= 1'b0;
            disp_addr_q   <= FB_BASE;
            starve_cnt_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            cmd_op_q      <= cmd_op_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_valid_q   <= cmd_valid_d;
            mcu_gnt_q     <= mcu_gnt_d;
            wr_ack_q      <= wr_ack_d;
            psram_ctrl_q  <= psram_ctrl_d;
            frame_start_q <= frame_start_d;
            disp_addr_q   <= disp_addr_d;
            starve_cnt_q  <= starve_cnt_d;
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_op      = cmd_op_q;
    assign bus.cmd_addr    = cmd_addr_q;
    assign bus.mcu_gnt     = mcu_gnt_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.psram_ctrl  = psram_ctrl_q;
    assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_bus_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_psram_bus_scheduler
// Description : Directed bench for psram_bus_scheduler with a command-engine
//               responder; small framebuffer so the address wrap is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_bus_scheduler;

    localparam logic [21:0] C_FB_BASE  = 22'h000000;
    localparam logic [21:0] C_FB_WORDS = 22'd384;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    psram_bus_scheduler_if bus ();

    psram_bus_scheduler #(
        .FB_BASE      (C_FB_BASE),
        .FB_WORDS     (C_FB_WORDS),
        .BURST_WORDS  (8'd16),
        .FIFO_DEPTH   (11'd512),
        .MCU_MAX_WAIT (16'd1024)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned busy_cnt = 0;
    int unsigned fs_cnt = 0, wack_cnt = 0, wack_cyc = 0, done_cyc = 0;
    int unsigned viol = 0, valid_seen = 0;
    logic [1:0]  log_op   [$];
    logic [21:0] log_addr [$];
    int unsigned log_cyc  [$];

    // Command engine: accepts on first sight, finishes 'lat' cycles later.
    initial begin
        bus.cmd_ready = 1'b0;
        bus.cmd_done  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.cmd_ready = 1'b0;
            bus.cmd_done  = 1'b0;
            if (!reset_n) begin
                busy_cnt = 0;
            end else begin
                if (bus.frame_start) fs_cnt++;
                if (bus.wr_ack) begin
                    wack_cnt++;
                    wack_cyc = cyc;
                end
                if (bus.cmd_valid) valid_seen++;
                if (bus.cmd_valid && !bus.psram_ctrl) viol++;
                if (busy_cnt != 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) begin
                        bus.cmd_done = 1'b1;
                        done_cyc = cyc;
                    end
                end
                if (bus.cmd_valid) begin
                    bus.cmd_ready = 1'b1;
                    log_op.push_back(bus.cmd_op);
                    log_addr.push_back(bus.cmd_addr);
                    log_cyc.push_back(cyc);
                    busy_cnt = lat;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (log_op.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_arrived"}, 32'(log_op.size() >= n), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_valid"},   32'(bus.cmd_valid),   32'd0);
        check({pfx, "_cmd_op"},      32'(bus.cmd_op),      32'd0);
        check({pfx, "_cmd_addr"},    32'(bus.cmd_addr),    32'd0);
        check({pfx, "_psram_ctrl"},  32'(bus.psram_ctrl),  32'd1);
        check({pfx, "_mcu_gnt"},     32'(bus.mcu_gnt),     32'd0);
        check({pfx, "_wr_ack"},      32'(bus.wr_ack),      32'd0);
        check({pfx, "_frame_start"}, 32'(bus.frame_start), 32'd0);
    endtask

    initial begin
        int n0;
        int errs;
        int k;
        int unsigned c0;
        int unsigned fs0;
        int unsigned el;

        bus.init_done    = 1'b0;
        bus.fifo_wrusedw = 10'd0;
        bus.fifo_wrfull  = 1'b0;
        bus.mcu_req      = 1'b0;
        bus.wr_req       = 1'b0;
        bus.wr_addr      = 22'd0;
        reset_n          = 1'b0;

        // Reset and init gating
        tick(5);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick(100);
        check("init_gate_no_cmd", valid_seen, 32'd0);
        bus.init_done = 1'b1;
        tick(2);
        check("init_valid_2cyc", 32'(bus.cmd_valid), 32'd1);
        check("init_op_read",    32'(bus.cmd_op),    32'd0);
        check("init_addr_base",  32'(bus.cmd_addr),  32'd0);

        // Refill stepping and wrap
        wait_log(25, 200, "refill25");
        tick(1);
        errs = 0;
        for (int i = 0; i < 25; i++) begin
            if (log_op[i] != 2'd0 || log_addr[i] != 22'((i * 16) % 384)) errs++;
        end
        check("refill_seq_errs",  32'(errs),         32'd0);
        check("refill_addr1",     32'(log_addr[1]),  32'd16);
        check("refill_addr23",    32'(log_addr[23]), 32'd368);
        check("refill_wrap_addr", 32'(log_addr[24]), 32'd0);
        check("frame_start_cnt",  fs_cnt,            32'd2);

        // Refill threshold: 497 stops, 496 resumes, full stops
        bus.fifo_wrusedw = 10'd497;
        tick(10);
        n0 = log_op.size();
        tick(40);
        check("no_refill_497", 32'(log_op.size()), 32'(n0));
        bus.fifo_wrusedw = 10'd496;
        wait_log(n0 + 1, 10, "refill_496");
        bus.fifo_wrusedw = 10'd497;
        check("refill_496_op", 32'(log_op[log_op.size() - 1]), 32'd0);
        tick(10);
        bus.fifo_wrusedw = 10'd0;
        bus.fifo_wrfull  = 1'b1;
        n0 = log_op.size();
        tick(20);
        check("no_refill_full", 32'(log_op.size()), 32'(n0));
        bus.fifo_wrfull  = 1'b0;
        bus.fifo_wrusedw = 10'd497;

        // Host write burst
        lat = 4;
        n0 = log_op.size();
        bus.wr_addr = 22'h12340;
        bus.wr_req  = 1'b1;
        wait_log(n0 + 1, 10, "write");
        check("write_op",   32'(log_op[n0]),   32'd1);
        check("write_addr", 32'(log_addr[n0]), 32'h12340);
        k = 0;
        while (wack_cnt == 0 && k < 20) begin
            tick(1);
            k++;
        end
        bus.wr_req = 1'b0;
        check("wr_ack_timing", wack_cyc, done_cyc + 1);
        tick(10);
        check("wr_ack_once",     wack_cnt,            32'd1);
        check("write_no_repeat", 32'(log_op.size()), 32'(n0 + 1));

        // MCU window
        lat = 3;
        n0 = log_op.size();
        bus.mcu_req = 1'b1;
        wait_log(n0 + 1, 10, "mcu_exit");
        check("mcu_exit_op",      32'(log_op[n0]),    32'd2);
        check("mcu_exit_addr",    32'(log_addr[n0]),  32'd0);
        check("mcu_ctrl_pre_done", 32'(bus.psram_ctrl), 32'd1);
        k = 0;
        while (bus.psram_ctrl && k < 20) begin
            tick(1);
            k++;
        end
        check("mcu_ctrl_drop_cyc", cyc, done_cyc + 1);
        check("mcu_gnt_on_done",   32'(bus.mcu_gnt), 32'd1);
        tick(10);
        check("mcu_win_ctrl",   32'(bus.psram_ctrl),  32'd0);
        check("mcu_win_gnt",    32'(bus.mcu_gnt),     32'd1);
        check("mcu_win_no_cmd", 32'(log_op.size()), 32'(n0 + 1));
        bus.mcu_req = 1'b0;
        tick(1);
        check("mcu_rel_gnt",   32'(bus.mcu_gnt),    32'd0);
        check("mcu_rel_ctrl",  32'(bus.psram_ctrl), 32'd1);
        check("mcu_rel_valid", 32'(bus.cmd_valid),  32'd1);
        check("mcu_rel_op",    32'(bus.cmd_op),     32'd3);
        tick(10);
        check("mcu_enter_cnt", 32'(log_op.size()), 32'(n0 + 2));
        check("mcu_enter_op",  32'(log_op[log_op.size() - 1]), 32'd3);

        // Starvation: MCU beats refill after 1024 waiting cycles
        lat = 1;
        bus.fifo_wrusedw = 10'd0;
        tick(3);
        c0 = cyc;
        bus.mcu_req = 1'b1;
        k = 0;
        while (log_op[log_op.size() - 1] != 2'd2 && k < 1100) begin
            tick(1);
            k++;
        end
        el = log_cyc[log_cyc.size() - 1] - c0;
        check("starve_exit_seen", 32'(log_op[log_op.size() - 1]), 32'd2);
        check("starve_delay_ok",  32'(el >= 1025 && el <= 1028), 32'd1);
        check("starve_prev_read", 32'(log_op[log_op.size() - 2]), 32'd0);
        k = 0;
        while (!bus.mcu_gnt && k < 20) begin
            tick(1);
            k++;
        end
        check("starve_gnt", 32'(bus.mcu_gnt), 32'd1);
        bus.mcu_req = 1'b0;
        tick(10);

        // Reset in the middle of a read burst
        lat = 30;
        n0 = log_op.size();
        k = 0;
        while (!(log_op.size() > n0 && log_addr[log_addr.size() - 1] != 22'd0) && k < 300) begin
            tick(1);
            k++;
        end
        check("midburst_read_seen", 32'(log_op.size() > n0), 32'd1);
        tick(3);
        reset_n = 1'b0;
        tick(1);
        check_reset_outputs("midrst");
        tick(2);
        lat = 1;
        fs0 = fs_cnt;
        n0 = log_op.size();
        reset_n = 1'b1;
        wait_log(n0 + 1, 10, "post_rst");
        check("post_rst_op",   32'(log_op[n0]),   32'd0);
        check("post_rst_addr", 32'(log_addr[n0]), 32'd0);
        tick(1);
        check("post_rst_frame_start", fs_cnt, fs0 + 1);

        check("no_cmd_while_mcu_owns", viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psram_bus_scheduler.md
Name: psram_bus_scheduler

Overview:
- Sequences the shared QSPI PSRAM between three requesters:
  - LCD line-buffer refill (read bursts into the display FIFO).
  - A host write-burst port.
  - The external MCU pass-through window, which needs quad-mode exit and re-entry around it.
- Issues one command at a time to the PSRAM command engine and generates the framebuffer read address.
- Owns the bus-ownership select (psram_ctrl).

Parameters:
- FB_BASE, 22'h000000, word address of framebuffer start.
- FB_WORDS, 22'd384000, framebuffer size in 16-bit words (800x480).
- BURST_WORDS, 8'd16, words per read or write burst; refill address step.
- FIFO_DEPTH, 11'd512, display FIFO depth in words.
- MCU_MAX_WAIT, 16'd1024, cycles of pending MCU request before MCU outranks display refill.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  in  1  engine finished PSRAM power-up/reset sequence; level.
- fifo_wrusedw  in  10  display FIFO write-side fill level.
- fifo_wrfull  in  1  display FIFO full.
- mcu_req  in  1  MCU requests bus window; already synchronised; level.
- mcu_gnt  out  1  MCU owns the bus while high.
- wr_req  in  1  host write-burst request; held until wr_ack.
- wr_addr  in  22  host burst start word address; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse when the host write burst completes.
- cmd_valid  out  1  command offered to the engine.
- cmd_op  out  2  0 READ_BURST, 1 WRITE_BURST, 2 EXIT_QUAD, 3 ENTER_QUAD.
- cmd_addr  out  22  burst start address; 0 for mode commands.
- cmd_ready  in  1  engine accepts the command this cycle.
- cmd_done  in  1  one-cycle pulse when the accepted command fully finishes (CS deasserted).
- psram_ctrl  out  1  1 = FPGA engine drives PSRAM pins, 0 = MCU drives.
- frame_start  out  1  one-cycle pulse when a READ_BURST at FB_BASE is accepted.

Behaviour:
- Reset values (async, on reset_n low):
  - state WAIT_INIT; mcu_gnt 0; wr_ack 0; cmd_valid 0; cmd_op 0; cmd_addr 0.
  - psram_ctrl 1; frame_start 0; disp_addr FB_BASE; starve_cnt 0.
  - Reset mid-command abandons it; the engine is reset by the same net.
- States:
  - WAIT_INIT: leave to SELECT when init_done = 1.
  - SELECT, evaluated in one cycle:
    - refill_ok = (FIFO_DEPTH - {1'b0,fifo_wrusedw}) >= BURST_WORDS && !fifo_wrfull. Subtraction is 11-bit unsigned.
    - Priority:
      1. MCU if mcu_req && starve_cnt >= MCU_MAX_WAIT.
      2. Refill if refill_ok.
      3. Write if wr_req.
      4. MCU if mcu_req.
      5. Otherwise stay.
    - Next state ISSUE with the chosen op; for MCU the op is EXIT_QUAD.
  - ISSUE: cmd_valid = 1 with op/addr registered. On cmd_ready: cmd_valid goes to 0 next cycle, go to BUSY. No timeout.
  - BUSY: wait for cmd_done, then act by op:
    - READ_BURST: disp_addr += BURST_WORDS. If the result is >= FB_BASE + FB_WORDS, wrap to FB_BASE. Go to SELECT.
    - WRITE_BURST: pulse wr_ack in the same cycle as the transition. Go to SELECT.
    - EXIT_QUAD: psram_ctrl <= 0; mcu_gnt <= mcu_req. Go to MCU_WIN.
    - ENTER_QUAD: go to SELECT.
  - MCU_WIN: when mcu_req = 0, mcu_gnt <= 0 and psram_ctrl <= 1 in the same cycle. Issue ENTER_QUAD via ISSUE/BUSY. If mcu_req already dropped during exit, the window is entered without a grant and exited at once.
- Latency:
  - SELECT to cmd_valid: 1 cycle.
  - cmd_done to next cmd_valid: 2 cycles minimum (BUSY to SELECT to ISSUE).
- starve_cnt: 16-bit counter.
  - Increments each cycle while mcu_req = 1 && mcu_gnt = 0; saturates at 16'hFFFF.
  - Cleared when mcu_gnt rises or mcu_req = 0.
- Read addresses: READ_BURST cmd_addr = disp_addr. frame_start pulses on cmd_ready acceptance when disp_addr == FB_BASE.
- Write addresses: WRITE_BURST cmd_addr = wr_addr, sampled in SELECT.
- Bus ownership: psram_ctrl is 0 only between EXIT_QUAD done and MCU release. cmd_valid is never asserted while psram_ctrl = 0.
- Simultaneous events:
  - cmd_done and a new request in the same cycle: the request is evaluated in the next SELECT.
  - wr_req dropping before wr_ack is illegal; behaviour is undefined.

Test Plan:
- Init gating: reset_n low 5 cycles, init_done held 0 for 100 cycles with fifo_wrusedw = 0 -> cmd_valid stays 0. init_done = 1 -> READ_BURST at 22'h000000 within 2 cycles, frame_start pulses once.
- Refill and wrap: fifo_wrusedw = 0, engine acks every burst -> cmd_addr steps by 16. After burst 23999 (addr 383984), next addr = 0 with frame_start. At fifo_wrusedw = 497, no refill is issued.
- Write port: refill_ok = 0, wr_req = 1, wr_addr = 22'h12340 -> WRITE_BURST @22'h12340. wr_ack pulses once, exactly on cmd_done.
- MCU window: mcu_req = 1, no refill -> EXIT_QUAD, then psram_ctrl = 0 and mcu_gnt = 1 on its done. mcu_req = 0 -> gnt 0 and psram_ctrl 1 the same cycle, then ENTER_QUAD issued.
- Starvation: fifo_wrusedw pinned at 0, mcu_req = 1 -> after 1024 waiting cycles the next SELECT chooses EXIT_QUAD over READ_BURST.
- Reset mid-burst: reset_n low during BUSY of a READ_BURST -> all outputs return to reset values next edge. disp_addr restarts at FB_BASE.
